// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one difference bit per clock, LSB first,
// with unsigned borrow and signed overflow flags presented together with the result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf,
  output logic             o_sbit,
  output logic             o_sbit_valid
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic [CNT_W-1:0] cnt;
  logic             bin;
  logic             a_bit, b_bit, d_bit, bout, last_bit;

  function automatic logic sub_diff(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  function automatic logic sub_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  always_comb begin
    a_bit    = a_sh[0];
    b_bit    = b_sh[0];
    d_bit    = sub_diff(a_bit, b_bit, bin);
    bout     = sub_borrow(a_bit, b_bit, bin);
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nxt    = state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_sbit       = 1'b0;
    o_sbit_valid = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        o_busy       = 1'b1;
        o_sbit       = d_bit;
        o_sbit_valid = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sh    <= i_a;
            b_sh    <= i_b;
            diff_sh <= '0;
            cnt     <= '0;
            bin     <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
          bin     <= bout;
          cnt     <= cnt + CNT_W'(1);
          // On the last bit a_bit/b_bit/d_bit are the sign bits of a, b and the difference.
          if (last_bit) begin
            o_diff   <= {d_bit, diff_sh[WIDTH-1:1]};
            o_borrow <= bout;
            o_ovf    <= (a_bit != b_bit) && (d_bit != a_bit);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         i_rst, i_start;
  logic [W-1:0] i_a, i_b;
  logic         o_busy, o_done, o_borrow, o_ovf, o_sbit, o_sbit_valid;
  logic [W-1:0] o_diff;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [W-1:0] sbits;
  int           sbits_n = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_diff(o_diff), .o_borrow(o_borrow),
    .o_ovf(o_ovf), .o_sbit(o_sbit), .o_sbit_valid(o_sbit_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t   e;
    int     ai, bi;
    longint sa, sb, sd;
    ai       = a;
    bi       = b;
    sa       = $signed(a);
    sb       = $signed(b);
    sd       = sa - sb;
    e.diff   = W'(ai - bi);
    e.borrow = (ai < bi);
    e.ovf    = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    e.acc    = acc;
    return e;
  endfunction

  // Monitor: gather serial bits, and on every o_done pop the oldest expectation.
  always @(negedge clk) begin
    if (!o_busy) sbits_n = 0;
    else if (o_sbit_valid && sbits_n < W) begin
      sbits[sbits_n] = o_sbit;
      sbits_n++;
    end
    if (o_done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", o_diff, e.diff);
        chk("borrow", o_borrow, e.borrow);
        chk("ovf", o_ovf, e.ovf);
        // The edge that first samples o_done high is cyc+1.
        chk("done_latency", cyc + 1 - e.acc, W + 1);
        chk("sbit_count", sbits_n, W);
        chk("sbit_seq", sbits, e.diff);
        chk("busy_in_done", o_busy, 1);
      end
      sbits_n = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    wait_idle();
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    i_start = 1'b0;
    i_a     = W'($urandom);
    i_b     = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_diff"}, o_diff, 0);
    chk({tag, "_borrow"}, o_borrow, 0);
    chk({tag, "_ovf"}, o_ovf, 0);
    chk({tag, "_sbit_valid"}, o_sbit_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a start request present: the request must be discarded.
    i_rst = 1'b1; i_start = 1'b1; i_a = 8'h11; i_b = 8'h22;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", o_busy, 0);

    issue(8'h05, 8'h03); drain();
    issue(8'h03, 8'h05); drain();
    issue(8'h80, 8'h01); drain();
    issue(8'h00, 8'h00); drain();
    issue(8'h7F, 8'hFF); drain();

    // Start request in mid-operation must be ignored.
    issue(8'h10, 8'h01);
    repeat (3) @(negedge clk);
    i_start = 1'b1; i_a = 8'hFF; i_b = 8'hFF;
    @(negedge clk);
    i_start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);
    chk("ignored_start_idle", o_busy, 0);

    // Abort in SHIFT: outputs clear, no o_done.
    issue(8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk_cleared("abort");
    i_rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("abort_no_done_idle", o_busy, 0);
    issue(8'h09, 8'h04); drain();

    // Start held high: a new operation every W+2 cycles.
    @(negedge clk);
    wait_idle();
    i_a = 8'h07; i_b = 8'h02; i_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q.push_back(model(8'h07, 8'h02, cyc + 1));
      repeat (W + 2) @(negedge clk);
    end
    i_start = 1'b0;
    drain();

    for (int n = 0; n < 40; n++) begin
      issue(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_idle", o_busy, 0);
    chk("final_sbit_valid", o_sbit_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
